// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake plus operand and result
// buses for the bit-serial subtractor. The ovf signal exists only when
// SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    // Requester side: issues operands, observes status and result.
    modport master (
        output start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        input  busy, done, diff, bout
    );

    // Subtractor side: consumes operands, produces status and result.
    modport slave (
        input  start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial N-bit subtractor computing a - b - bin,
// LSB first, one full-subtractor cell evaluated per clock with the borrow
// carried between bits in a flip-flop. A result takes N+1 cycles from the
// accepting edge to the done pulse; diff/bout are held in a result register
// that only changes when a new result completes.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
// output ovf (borrow into MSB xor borrow out of MSB).
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_subtractor_if.slave    bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       next_state;

    logic [N-1:0]  sa;        // minuend, shifted right as bits are consumed
    logic [N-1:0]  sb;        // subtrahend, shifted right as bits are consumed
    logic [N-2:0]  sd;        // partial difference: the N-1 bits finished so far
    logic          br;        // borrow into the bit being processed
    logic [CW-1:0] cnt;       // index of the bit being processed

    logic [N-1:0]  diff_q;
    logic          bout_q;
`ifdef SERIAL_SUB_OVF_EN
    logic          ovf_q;
`endif

    logic          d;
    logic          bo;
    logic          last;
    logic          load;
    logic [N-1:0]  sd_next;
    logic          busy_c;
    logic          done_c;

    // Full-subtractor cell for the current bit plus load/last-bit decode.
    always_comb begin
        d       = sa[0] ^ sb[0] ^ br;
        bo      = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        sd_next = {d, sd};
        last    = (cnt == CW'(N - 1));
        load    = bus.start && ((state == IDLE) || (state == DONE));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        next_state = state;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) next_state = RUN;
            end
            RUN: begin
                busy_c = 1'b1;
                if (last) next_state = DONE;
            end
            DONE: begin
                done_c     = 1'b1;
                next_state = bus.start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand shift registers, borrow flop and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa  <= '0;
            sb  <= '0;
            sd  <= '0;
            br  <= 1'b0;
            cnt <= '0;
        end else if (load) begin
            sa  <= bus.a;
            sb  <= bus.b;
            sd  <= '0;
            br  <= bus.bin;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= {1'b0, sa[N-1:1]};
            sb  <= {1'b0, sb[N-1:1]};
            sd  <= sd_next[N-1:1];
            br  <= bo;
            // Return to zero after the last bit so the count stays within 0..N-1.
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    // Result register: updated only on the edge that finishes bit N-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q <= '0;
            bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else if ((state == RUN) && last) begin
            diff_q <= sd_next;
            bout_q <= bo;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= br ^ bo;
`endif
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table-driven directed vectors, hand-written
// back-to-back / start-during-run / mid-run reset sequences, and random
// operations checked against an arithmetic reference model.
module tb_serial_subtractor;
    localparam int N = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    serial_subtractor_if #(.N(N)) bus ();

    serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [N-1:0] last_diff = '0;
    logic         last_bout = 1'b0;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         bin;
        logic [N-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                         output logic [N-1:0] diff, output logic bout, output logic ovf);
        int r;
        int sa;
        int sb;
        r    = int'(a) - int'(b) - int'(bin);
        diff = r[N-1:0];
        bout = (r < 0);
        sa   = $signed(a);
        sb   = $signed(b);
        r    = sa - sb - int'(bin);
        ovf  = (r < -(2 ** (N - 1))) || (r > (2 ** (N - 1)) - 1);
    endtask

    // Present an operation; caller is at a negedge, accepted at the next posedge.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
    endtask

    // Walk cycles 1..N (busy, result held) then check the done cycle N+1.
    // With hold set, start stays high and operands keep changing during RUN.
    task automatic collect(input logic [N-1:0] ed, input logic eb, input logic eo,
                           input logic hold, input string name);
        logic busy_ok = 1'b1;
        logic held_ok = 1'b1;
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            if (hold) begin
                bus.a   = N'($urandom);
                bus.b   = N'($urandom);
                bus.bin = 1'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_ok = 1'b0;
            if (bus.diff !== last_diff || bus.bout !== last_bout) held_ok = 1'b0;
        end
        @(negedge clk);
        check({name, " busy cycles 1..N"}, 32'(busy_ok), 32'd1);
        check({name, " result held during run"}, 32'(held_ok), 32'd1);
        check({name, " done"}, 32'(bus.done), 32'd1);
        check({name, " busy in done"}, 32'(bus.busy), 32'd0);
        check({name, " diff"}, 32'(bus.diff), 32'(ed));
        check({name, " bout"}, 32'(bus.bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        check({name, " ovf"}, 32'(bus.ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("note: unknown ovf expectation in %s", name);
`endif
        last_diff = ed;
        last_bout = eb;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " busy"}, 32'(bus.busy), 32'd0);
        check({name, " done"}, 32'(bus.done), 32'd0);
        check({name, " diff"}, 32'(bus.diff), 32'd0);
        check({name, " bout"}, 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check({name, " ovf"}, 32'(bus.ovf), 32'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] ed;
        logic         eb;
        logic         eo;
        logic [N-1:0] ha;
        logic [N-1:0] hb;
        logic         hbin;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table, one isolated operation each.
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].bin);
            collect(vecs[i].diff, vecs[i].bout, vecs[i].ovf, 1'b0, $sformatf("vec%0d", i));
            bus.start = 1'b0;
            @(negedge clk);
        end

        // Borrow-in followed by a start accepted in the done cycle.
        issue(8'h10, 8'h0F, 1'b1);
        collect(8'h00, 1'b0, 1'b0, 1'b0, "b2b op1");
        issue(8'h03, 8'h05, 1'b0);
        collect(8'hFE, 1'b1, 1'b0, 1'b0, "b2b op2");
        bus.start = 1'b0;
        @(negedge clk);

        // Reset asserted in cycle 4 of RUN aborts and clears outputs at once.
        issue(8'h44, 8'h22, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-run reset");
        last_diff = '0;
        last_bout = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(8'hFF, 8'h0F, 1'b0);
        collect(8'hF0, 1'b0, 1'b0, 1'b0, "after reset");
        bus.start = 1'b0;
        @(negedge clk);

        // Start held through RUN with changing operands: first result intact,
        // next op uses the operands present at the done-cycle edge.
        issue(8'h21, 8'h13, 1'b0);
        collect(8'h0E, 1'b0, 1'b0, 1'b1, "held start op1");
        ha   = bus.a;
        hb   = bus.b;
        hbin = bus.bin;
        model(ha, hb, hbin, ed, eb, eo);
        collect(ed, eb, eo, 1'b0, "held start op2");
        bus.start = 1'b0;
        @(negedge clk);

        // Random operations, mixing idle gaps and back-to-back starts.
        for (int i = 0; i < 40; i++) begin
            ha   = N'($urandom);
            hb   = N'($urandom);
            hbin = 1'($urandom);
            model(ha, hb, hbin, ed, eb, eo);
            issue(ha, hb, hbin);
            collect(ed, eb, eo, 1'b0, $sformatf("rand%0d", i));
            if ($urandom_range(1, 0) == 0) begin
                bus.start = 1'b0;
                repeat ($urandom_range(2, 1)) @(negedge clk);
            end
        end
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
